// File: rtl/ex_redirect.sv
// EX-stage redirect controller: resolves jumps/branches and memory-indirect jumps
// into a registered PC redirect pulse, a two-cycle pipeline flush and a stall.
module ex_redirect #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_neg,
    input  logic              branch_zero,
    input  logic              jump,
    input  logic              jumpmem,
    input  logic [DATA_W-1:0] rs,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_req,
    output logic [DATA_W-1:0] mem_addr,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush,
    output logic              stall,
    output logic [COUNT_W-1:0] redirect_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic               flush_last_q, flush_last_d;
    logic               mem_req_q, mem_req_d;
    logic               stall_q, stall_d;
    logic               pc_redirect_q, pc_redirect_d;
    logic               flush_q, flush_d;
    logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  pc_target_q, pc_target_d;
    logic [COUNT_W-1:0] redirect_count_q, redirect_count_d;
    logic               take;
    logic               cond_taken;

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == {COUNT_W{1'b1}}) ? v : v + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign cond_taken = jump | (branch_zero & alu_zero) | (branch_neg & alu_neg);

    always_comb begin
        state_d          = state_q;
        flush_last_d     = flush_last_q;
        mem_req_d        = mem_req_q;
        stall_d          = stall_q;
        pc_redirect_d    = 1'b0;
        flush_d          = flush_q;
        mem_addr_d       = mem_addr_q;
        pc_target_d      = pc_target_q;
        redirect_count_d = redirect_count_q;
        take             = 1'b0;

        case (state_q)
            IDLE: begin
                if (jumpmem) begin
                    mem_addr_d = rs;
                    mem_req_d  = 1'b1;
                    stall_d    = 1'b1;
                    state_d    = MEMWAIT;
                end else if (cond_taken) begin
                    pc_target_d = rs;
                    take        = 1'b1;
                end
            end
            MEMWAIT: begin
                if (mem_rvalid) begin
                    pc_target_d = mem_rdata;
                    mem_req_d   = 1'b0;
                    stall_d     = 1'b0;
                    take        = 1'b1;
                end
            end
            FLUSH: begin
                // Inputs here belong to squashed instructions and are ignored.
                if (flush_last_q) begin
                    state_d      = IDLE;
                    flush_d      = 1'b0;
                    flush_last_d = 1'b0;
                end else begin
                    flush_last_d = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                flush_d      = 1'b0;
                flush_last_d = 1'b0;
                mem_req_d    = 1'b0;
                stall_d      = 1'b0;
            end
        endcase

        if (take) begin
            state_d          = FLUSH;
            flush_last_d     = 1'b0;
            pc_redirect_d    = 1'b1;
            flush_d          = 1'b1;
            redirect_count_d = sat_inc(redirect_count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            flush_last_q     <= 1'b0;
            mem_req_q        <= 1'b0;
            stall_q          <= 1'b0;
            pc_redirect_q    <= 1'b0;
            flush_q          <= 1'b0;
            mem_addr_q       <= '0;
            pc_target_q      <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            flush_last_q     <= flush_last_d;
            mem_req_q        <= mem_req_d;
            stall_q          <= stall_d;
            pc_redirect_q    <= pc_redirect_d;
            flush_q          <= flush_d;
            mem_addr_q       <= mem_addr_d;
            pc_target_q      <= pc_target_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign stall          = stall_q;
    assign pc_redirect    = pc_redirect_q;
    assign flush          = flush_q;
    assign mem_addr       = mem_addr_q;
    assign pc_target      = pc_target_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_ex_redirect.sv
// Bench for ex_redirect: directed scenarios plus randomized traffic checked
// against a transaction-level model of the redirect rules.
module tb_ex_redirect;

    logic        clk;
    logic        rst_n;
    logic        branch_neg, branch_zero, jump, jumpmem;
    logic [31:0] rs;
    logic        alu_zero, alu_neg;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        pc_redirect;
    logic [31:0] pc_target;
    logic        flush;
    logic        stall;
    logic [15:0] redirect_count;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic        m_req, m_stall, m_redirect, m_flush, m_wait;
    logic [31:0] m_addr, m_target;
    logic [15:0] m_count;
    int          m_left;

    ex_redirect dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branch_neg     (branch_neg),
        .branch_zero    (branch_zero),
        .jump           (jump),
        .jumpmem        (jumpmem),
        .rs             (rs),
        .alu_zero       (alu_zero),
        .alu_neg        (alu_neg),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .pc_redirect    (pc_redirect),
        .pc_target      (pc_target),
        .flush          (flush),
        .stall          (stall),
        .redirect_count (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        branch_neg = 0; branch_zero = 0; jump = 0; jumpmem = 0;
        alu_zero = 0; alu_neg = 0; mem_rvalid = 0;
        rs = $urandom; mem_rdata = $urandom;
    endtask

    task automatic model_reset();
        m_req = 0; m_stall = 0; m_redirect = 0; m_flush = 0; m_wait = 0;
        m_addr = 0; m_target = 0; m_count = 0; m_left = 0;
    endtask

    task automatic model_take();
        m_left = 2;
        m_redirect = 1;
        m_flush = 1;
        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
    endtask

    task automatic model_edge();
        m_redirect = 0;
        if (m_left > 0) begin
            m_left = m_left - 1;
            m_flush = (m_left > 0);
        end else if (m_wait) begin
            if (mem_rvalid) begin
                m_target = mem_rdata;
                m_req = 0; m_stall = 0; m_wait = 0;
                model_take();
            end
        end else if (jumpmem) begin
            m_addr = rs; m_req = 1; m_stall = 1; m_wait = 1;
        end else if (jump || (branch_zero && alu_zero) || (branch_neg && alu_neg)) begin
            m_target = rs;
            model_take();
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (pc_redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", pc_redirect); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (pc_target !== 32'h0) begin errors++; $display("FAIL reset_pc_target: got %h want 0", pc_target); end
        checks++; if (redirect_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h want 0", redirect_count); end
        rst_n = 1;
    endtask

    task automatic test_jump();
        jump = 1; rs = 32'h40;
        step();
        clear_inputs();
        checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h40) begin errors++; $display("FAIL jump_redirect: got %b/%h want 1/00000040", pc_redirect, pc_target); end
        checks++; if (flush !== 1'b1 || redirect_count !== 16'd1) begin errors++; $display("FAIL jump_flush1: got flush=%b count=%0d want 1/1", flush, redirect_count); end
        jump = 1; rs = 32'hDEAD;
        step();
        checks++; if (pc_redirect !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL jump_flush2: got redirect=%b flush=%b want 0/1", pc_redirect, flush); end
        step();
        clear_inputs();
        checks++; if (flush !== 1'b0 || pc_redirect !== 1'b0 || pc_target !== 32'h40) begin errors++; $display("FAIL jump_end: got flush=%b redirect=%b target=%h want 0/0/00000040", flush, pc_redirect, pc_target); end
    endtask

    task automatic test_branch_zero();
        branch_zero = 1; alu_zero = 0; rs = 32'h100;
        step();
        checks++; if (pc_redirect !== 1'b0 || flush !== 1'b0 || redirect_count !== m_count || pc_target !== m_target) begin errors++; $display("FAIL bz_not_taken: got redirect=%b flush=%b count=%0d target=%h want 0/0/%0d/%h", pc_redirect, flush, redirect_count, pc_target, m_count, m_target); end
        alu_zero = 1;
        step();
        clear_inputs();
        checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h100 || redirect_count !== m_count) begin errors++; $display("FAIL bz_taken: got redirect=%b target=%h count=%0d want 1/00000100/%0d", pc_redirect, pc_target, redirect_count, m_count); end
        step(); step();
    endtask

    task automatic test_jumpmem();
        jumpmem = 1; rs = 32'h20;
        step();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL jm_wait%0d: got req=%b stall=%b addr=%h want 1/1/00000020", i, mem_req, stall, mem_addr); end
            if (i == 2) begin mem_rvalid = 1; mem_rdata = 32'h1234; end
            else begin mem_rvalid = 0; mem_rdata = $urandom; end
            rs = $urandom;
            step();
        end
        clear_inputs();
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || pc_redirect !== 1'b1 || pc_target !== 32'h1234) begin errors++; $display("FAIL jm_done: got req=%b stall=%b redirect=%b target=%h want 0/0/1/00001234", mem_req, stall, pc_redirect, pc_target); end
        step();
        checks++; if (pc_redirect !== 1'b0 || flush !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL jm_pulse: got redirect=%b flush=%b addr=%h want 0/1/00000020", pc_redirect, flush, mem_addr); end
        step();
    endtask

    task automatic test_simultaneous();
        jumpmem = 1; jump = 1; rs = 32'h300;
        step();
        jumpmem = 0;
        checks++; if (mem_req !== 1'b1 || pc_redirect !== 1'b0 || mem_addr !== 32'h300) begin errors++; $display("FAIL sim_mem_path: got req=%b redirect=%b addr=%h want 1/0/00000300", mem_req, pc_redirect, mem_addr); end
        mem_rvalid = 1; mem_rdata = 32'h500; rs = 32'h999;
        step();
        mem_rvalid = 0;
        checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h500) begin errors++; $display("FAIL sim_redirect: got %b/%h want 1/00000500", pc_redirect, pc_target); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (pc_redirect !== 1'b0 || pc_target !== 32'h500) begin errors++; $display("FAIL sim_masked%0d: got redirect=%b target=%h want 0/00000500", i, pc_redirect, pc_target); end
        end
        step();
        clear_inputs();
        checks++; if (pc_redirect !== m_redirect || pc_target !== m_target || redirect_count !== m_count) begin errors++; $display("FAIL sim_after: got %b/%h/%0d want %b/%h/%0d", pc_redirect, pc_target, redirect_count, m_redirect, m_target, m_count); end
        step(); step();
    endtask

    task automatic test_reset_memwait();
        jumpmem = 1; rs = 32'h77;
        step();
        clear_inputs();
        step();
        #2;
        rst_n = 0;
        #1;
        model_reset();
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rst_mw_async: got req=%b stall=%b flush=%b want 0/0/0", mem_req, stall, flush); end
        checks++; if (mem_addr !== 32'h0 || redirect_count !== 16'h0) begin errors++; $display("FAIL rst_mw_regs: got addr=%h count=%0d want 0/0", mem_addr, redirect_count); end
        @(posedge clk); #1;
        rst_n = 1;
        jump = 1; rs = 32'h8;
        step();
        clear_inputs();
        checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h8 || redirect_count !== 16'd1 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_mw_after: got redirect=%b target=%h count=%0d req=%b want 1/00000008/1/0", pc_redirect, pc_target, redirect_count, mem_req); end
        step(); step();
    endtask

    task automatic test_saturation();
        force dut.redirect_count_q = 16'hFFFE;
        step();
        release dut.redirect_count_q;
        m_count = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            jump = 1; rs = $urandom;
            step();
            clear_inputs();
            checks++; if (redirect_count !== 16'hFFFF || pc_redirect !== 1'b1) begin errors++; $display("FAIL sat%0d: got count=%h redirect=%b want ffff/1", k, redirect_count, pc_redirect); end
            step(); step();
        end
        checks++; if (redirect_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", redirect_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            jumpmem     = ($urandom_range(0, 7) == 0);
            jump        = ($urandom_range(0, 5) == 0);
            branch_zero = $urandom_range(0, 1);
            alu_zero    = $urandom_range(0, 1);
            branch_neg  = $urandom_range(0, 1);
            alu_neg     = $urandom_range(0, 1);
            rs          = $urandom;
            mem_rvalid  = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            step();
            checks++;
            if (mem_req !== m_req || stall !== m_stall || pc_redirect !== m_redirect || flush !== m_flush ||
                mem_addr !== m_addr || pc_target !== m_target || redirect_count !== m_count) begin
                errors++;
                $display("FAIL rand%0d: got req=%b stall=%b redir=%b flush=%b addr=%h tgt=%h cnt=%0d want %b/%b/%b/%b/%h/%h/%0d",
                         i, mem_req, stall, pc_redirect, flush, mem_addr, pc_target, redirect_count,
                         m_req, m_stall, m_redirect, m_flush, m_addr, m_target, m_count);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_jump();
        test_branch_zero();
        test_jumpmem();
        test_simultaneous();
        test_reset_memwait();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_redirect.md
EX_REDIRECT -- requirements
Module: ex_redirect

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock for all state.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-003 The block SHALL have the ports branch_neg, branch_zero, jump and jumpmem, input, 1 bit each: the control bits of the instruction currently held in the ID/EX buffer.
REQ-004 The block SHALL have the port rs, input, 32 bits: the branch/jump target register value from the ID/EX buffer.
REQ-005 The block SHALL have the ports alu_zero and alu_neg, input, 1 bit each: the ALU flags for the same instruction.
REQ-006 The block SHALL have the port mem_rdata, input, 32 bits: data memory read data.
REQ-007 The block SHALL have the port mem_rvalid, input, 1 bit: mem_rdata is valid this cycle.
REQ-008 The block SHALL have the port mem_req, output, 1 bit: request a data memory read for jumpmem.
REQ-009 The block SHALL have the port mem_addr, output, 32 bits: the read address.
REQ-010 The block SHALL have the port pc_redirect, output, 1 bit: a one-cycle pulse telling the fetch stage to load pc_target.
REQ-011 The block SHALL have the port pc_target, output, 32 bits: the new PC value.
REQ-012 The block SHALL have the port flush, output, 1 bit: squash the IF/ID and ID/EX buffer contents.
REQ-013 The block SHALL have the port stall, output, 1 bit: freeze PC, IF/ID and ID/EX.
REQ-014 The block SHALL have the port redirect_count, output, 16 bits: the number of redirects taken.

Function
REQ-015 All outputs SHALL be driven from registers; there SHALL be no combinational path from any input to any output.
REQ-016 The block SHALL implement exactly three states: IDLE, MEMWAIT and FLUSH.
REQ-017 Inputs SHALL be evaluated only in IDLE, with priority jumpmem > jump > branch_zero&alu_zero > branch_neg&alu_neg.
REQ-018 A condition is taken when jump=1, or branch_zero&alu_zero=1, or branch_neg&alu_neg=1.
REQ-019 On a taken condition at the edge ending IDLE cycle N, the block SHALL latch pc_target=rs, assert pc_redirect for cycle N+1 only, assert flush in cycles N+1 and N+2, and enter FLUSH.
REQ-020 When jumpmem=1 at the edge ending IDLE cycle N, the block SHALL latch mem_addr=rs and drive mem_req=1 and stall=1 from cycle N+1, and enter MEMWAIT.
REQ-021 In MEMWAIT, mem_req and stall SHALL stay high and mem_addr SHALL stay stable until mem_rvalid=1 is sampled.
REQ-022 mem_rvalid=1 is legal in the first MEMWAIT cycle.
REQ-023 On the edge where mem_rvalid=1 is sampled in MEMWAIT, the block SHALL latch pc_target=mem_rdata and deassert mem_req and stall.
REQ-024 Following REQ-023, the block SHALL enter FLUSH with the same pc_redirect/flush timing as REQ-019, counted from that edge.
REQ-025 FLUSH SHALL last exactly two cycles, during which the control inputs SHALL be ignored (they belong to squashed instructions).
REQ-026 After FLUSH the block SHALL return to IDLE and resume sampling at the next edge.
REQ-027 mem_rvalid outside MEMWAIT SHALL be ignored.
REQ-028 MEMWAIT has no timeout; the block SHALL wait indefinitely.
REQ-029 pc_target SHALL hold its last value when no redirect is pending.
REQ-030 mem_addr SHALL hold its last value when mem_req=0.
REQ-031 redirect_count SHALL increment by 1 on each pc_redirect pulse and saturate at 0xFFFF with no wrap.
REQ-032 A not-taken branch (for example branch_zero=1 with alu_zero=0) SHALL produce no output change and SHALL NOT be counted.

Reset
REQ-033 When rst_n=0 the block SHALL immediately, without waiting for clk, force state IDLE and set mem_req, pc_redirect, flush and stall to 0, mem_addr and pc_target to 0x00000000, and redirect_count to 0x0000.
REQ-034 Reset asserted during MEMWAIT or FLUSH SHALL abort the operation and drop mem_req and flush the same cycle.
REQ-035 After rst_n rises, the first edge SHALL sample inputs in IDLE.

Verification
REQ-036 Bench scenario, jump: jump=1, rs=0x00000040 at edge N -> pc_redirect=1 and pc_target=0x40 in cycle N+1, flush=1 in N+1..N+2, redirect_count=1.
REQ-037 Bench scenario, branch_zero not taken then taken: alu_zero=0 -> no redirect and count unchanged; then alu_zero=1, rs=0x100 -> redirect to 0x100.
REQ-038 Bench scenario, jumpmem: rs=0x20, mem_rvalid asserted 3 cycles after mem_req with mem_rdata=0x1234 -> mem_addr=0x20, stall=1 for 3 cycles, then pc_target=0x1234 with a one-cycle pc_redirect.
REQ-039 Bench scenario, simultaneous controls and FLUSH masking: jumpmem=1 and jump=1 together -> memory path taken; jump=1 held during FLUSH -> no second redirect.
REQ-040 Bench scenario, reset in MEMWAIT: rst_n=0 mid-MEMWAIT -> mem_req=0 and stall=0 immediately; after release, jump=1 with rs=0x8 -> normal redirect to 0x8.
REQ-041 Bench scenario, saturation: preload 65535 redirects, then one more -> redirect_count stays 0xFFFF.
